// File: rtl/rom_burst_reader.sv
// rom_burst_reader: streams bursts from a (i+1) constant ROM through a PIPE-stage read path and output FIFO.
// Define ROM_PARITY_EN to add rd_parity, the stored XOR of each rd_data word.
module rom_burst_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int PIPE   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy
`ifdef ROM_PARITY_EN
    ,
    output logic              rd_parity
`endif
);
    localparam int FD  = PIPE + 2;
    localparam int PTW = $clog2(FD);
    localparam int CW  = $clog2(2 * FD + 1);
    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return DATA_W'(int'(a) + 1);
    endfunction
    function automatic logic [PTW-1:0] ptr_inc(input logic [PTW-1:0] p);
        return (p == PTW'(FD - 1)) ? '0 : p + 1'b1;
    endfunction
    state_t            state, next;
    logic              alive, accept, issue, last_now, pop;
    logic [ADDR_W-1:0] addr, beats;
    logic              s_v, s_l;
    logic [DATA_W-1:0] s_d;
    logic [CW-1:0]     inflight, cnt;
    logic [PTW-1:0]    wp, rp;
    logic [DATA_W-1:0] mem_d [FD];
    logic [FD-1:0]     mem_l;
    assign accept   = req_valid && req_ready;
    assign last_now = beats == '0;
    assign pop      = rd_valid && rd_ready;
    assign busy     = state != IDLE;
    assign rd_valid = cnt != '0;
    assign rd_data  = rd_valid ? mem_d[rp] : '0;
    assign rd_last  = rd_valid && mem_l[rp];
    // req_ready stays low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) alive <= 1'b0;
        else        alive <= 1'b1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;
    always_comb begin
        next      = state;
        req_ready = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = alive;
                if (req_valid && alive) next = BURST;
            end
            BURST: begin
                issue = en && (cnt + inflight < CW'(FD));
                if (issue && last_now) next = DRAIN;
            end
            DRAIN: if (pop && rd_last) next = IDLE;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            addr  <= '0;
            beats <= '0;
        end else if (accept) begin
            addr  <= req_addr;
            beats <= req_len;
        end else if (issue) begin
            addr  <= addr + 1'b1;
            beats <= beats - 1'b1;
        end
    // The FIFO write is the final pipeline stage, so only PIPE-1 register stages sit in front of it
    generate
        if (PIPE == 1) begin : g_direct
            assign s_v      = issue;
            assign s_d      = rom_word(addr);
            assign s_l      = last_now;
            assign inflight = '0;
        end else begin : g_pipe
            logic [PIPE-2:0]   pv, pl;
            logic [DATA_W-1:0] pd [PIPE-1];
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    pv <= '0;
                    pl <= '0;
                end else begin
                    pv[0] <= issue;
                    pl[0] <= last_now;
                    for (int i = 1; i < PIPE - 1; i++) begin
                        pv[i] <= pv[i-1];
                        pl[i] <= pl[i-1];
                    end
                end
            always_ff @(posedge clk) begin
                pd[0] <= rom_word(addr);
                for (int i = 1; i < PIPE - 1; i++) pd[i] <= pd[i-1];
            end
            assign s_v      = pv[PIPE-2];
            assign s_l      = pl[PIPE-2];
            assign s_d      = pd[PIPE-2];
            assign inflight = CW'($countones(pv));
        end
    endgenerate
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (s_v) wp <= ptr_inc(wp);
            if (pop) rp <= ptr_inc(rp);
            cnt <= cnt + CW'(s_v) - CW'(pop);
        end
    always_ff @(posedge clk)
        if (s_v) begin
            mem_d[wp] <= s_d;
            mem_l[wp] <= s_l;
        end
`ifdef ROM_PARITY_EN
    logic [FD-1:0] mem_p;
    always_ff @(posedge clk)
        if (s_v) mem_p[wp] <= ^s_d;
    assign rd_parity = rd_valid && mem_p[rp];
`endif
endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: directed and random bursts checked against a queue model of the ROM contents.
module tb_rom_burst_reader;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int PIPE   = 2;
    localparam int DEPTH  = 32;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, req_valid = 1'b0, rd_ready = 1'b1;
    logic [ADDR_W-1:0] req_addr = '0, req_len = '0;
    logic req_ready, rd_valid, rd_last, busy;
    logic [DATA_W-1:0] rd_data;
`ifdef ROM_PARITY_EN
    logic rd_parity;
`endif
    int n_chk = 0, n_fail = 0;
    rom_burst_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PIPE(PIPE)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy)
`ifdef ROM_PARITY_EN
        , .rd_parity(rd_parity)
`endif
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    // rmode: 0 ready=1, 1 ready pattern 1,0,0, 2 random; emode: 0 en=1, 1 en low for cycles 3..7, 2 random
    task automatic burst(input int a, input int l, input int rmode, input int emode);
        int q_d[$];
        bit q_l[$];
        int c, t, first, lastc, nb;
        for (int k = 0; k <= l; k++) begin
            q_d.push_back((((a + k) % DEPTH) + 1) % 256);
            q_l.push_back(k == l);
        end
        @(negedge clk);
        req_addr  = ADDR_W'(a);
        req_len   = ADDR_W'(l);
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_idle", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
        check("busy_after_accept", busy, 1);
        check("req_ready_in_burst", req_ready, 0);
        c = 0; first = -1; lastc = -1; nb = 0;
        while (busy && c < 500) begin
            rd_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
            en       = (emode == 0) ? 1'b1 : (emode == 1) ? !(c >= 3 && c < 8) : ($urandom_range(0, 3) != 0);
            if (rd_valid && rd_ready) begin
                if (q_d.size() != 0) begin
                    check("data", rd_data, q_d[0]);
                    check("last", rd_last, q_l[0]);
`ifdef ROM_PARITY_EN
                    check("parity", rd_parity, ^q_d[0]);
`endif
                    void'(q_d.pop_front());
                    void'(q_l.pop_front());
                end
                if (first < 0) first = c;
                lastc = c;
                nb++;
            end
            @(negedge clk);
            c++;
        end
        check("burst_done", busy, 0);
        check("beat_count", nb, l + 1);
        check("req_ready_after", req_ready, 1);
        check("idle_no_valid", rd_valid, 0);
        if (rmode == 0 && emode == 0) begin
            check("latency", first, PIPE);
            check("contiguous", lastc - first, l);
        end
        if (emode == 1) check("en_gap", 32'(lastc - first > l), 1);
        en = 1'b1;
        rd_ready = 1'b1;
    endtask
    initial begin
        int seen;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_req_ready_pre", req_ready, 0);
        @(negedge clk);
        check("rel_req_ready", req_ready, 1);
        burst(3, 0, 0, 0);
        burst(30, 3, 0, 0);
        burst(0, 7, 1, 0);
        burst(10, 5, 0, 1);
        @(negedge clk);
        req_addr = 0; req_len = 15; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_beat2", rd_data, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_data", rd_data, 0);
        check("mid_rst_last", rd_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", req_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        @(negedge clk);
        check("mid_rel_ready", req_ready, 1);
        repeat (6) begin
            if (rd_valid || busy) seen++;
            @(negedge clk);
        end
        check("no_residual", seen, 0);
        burst(5, 0, 0, 0);
        for (int i = 0; i < 10; i++) burst($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), 2, 2);
        burst($urandom_range(0, DEPTH - 1), DEPTH - 1, 2, 0);
        burst(0, DEPTH - 1, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
Parametrised read-only lookup table, the successor to the fixed 8-entry byte ROM.
- Accepts a start-address/length burst request over a valid/ready handshake.
- Streams consecutive entries out through a PIPE-stage read pipeline and an output FIFO, with full backpressure.
- Sits between the sequencing logic and any consumer that needs table constants at one word per cycle.

Parameters:
DATA_W, 8, width of each ROM word
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (default 32x8)
PIPE, 2, read pipeline stages, legal range 1..4

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  issue enable; 0 freezes new reads, in-flight reads still complete
req_valid  input  1  burst request valid
req_ready  output  1  burst request accepted when req_valid && req_ready
req_addr  input  ADDR_W  burst start address
req_len  input  ADDR_W  burst length minus one (0 = 1 beat, max DEPTH beats)
rd_valid  output  1  rd_data valid
rd_ready  input  1  consumer accepts beat when rd_valid && rd_ready
rd_data  output  DATA_W  ROM word
rd_last  output  1  high with the final beat of the burst
busy  output  1  high from the accept edge until the last beat is popped

Behaviour:
- Contents: entry i = (i+1) mod 2**DATA_W, fixed at elaboration; DEPTH=32 gives 1..32.
- Reset, asynchronous: req_ready=0 while rst_n low, 1 on the first clock after release. rd_valid=0, rd_data=0, rd_last=0, busy=0. FIFO, pipeline and counters cleared. Mid-burst reset discards all beats; no partial data after release.
- FSM states:
  - IDLE: req_ready=1. On accept, load addr counter=req_addr and beat counter=req_len, then go to BURST.
  - BURST: req_ready=0. One read issued per cycle when en=1 and fifo_count+inflight < PIPE+2. No credit for a same-cycle pop. Each issue increments the address modulo DEPTH (31 -> 0 wrap) and decrements the beat counter. Issuing the beat with counter=0 goes to DRAIN.
  - DRAIN: no issues. Wait for the FIFO and pipeline to empty. On the edge the last beat is popped, go to IDLE and clear busy.
- Output FIFO: depth PIPE+2. rd_data and rd_last come from the FIFO head. Beats are never dropped or duplicated under any rd_ready pattern.
- Latency: with en=1 and rd_ready=1, rd_valid rises on the PIPE-th rising edge after the accept edge. Throughput is then 1 beat per cycle.
- rd_last is tagged at issue (beat counter==0) and travels with its data.
- en low in BURST: the issue point stalls and counters hold. Already-issued beats still arrive. Resuming en continues from the held address.
- req_valid is ignored outside IDLE. A new request is accepted no earlier than the cycle after busy falls.
- req_len=DEPTH-1 reads all entries once, wrapping through 0.

Optional Feature:
Macro ROM_PARITY_EN.
- Defined: adds output port rd_parity (1 bit), the even parity (XOR) of rd_data. It is stored in the FIFO alongside the data and is 0 at reset.
- Undefined: the port and its storage are absent, and behaviour is otherwise identical.

Test Plan:
- Single beat: req_addr=3, req_len=0, rd_ready=1 -> one beat rd_data=0x04, rd_last=1, rd_valid after 2 edges (PIPE=2); busy falls the same edge; req_ready=1 next cycle.
- Wrap burst: req_addr=30, req_len=3 -> beats 0x1F, 0x20, 0x01, 0x02 on consecutive cycles; rd_last only on 0x02.
- Backpressure: req_addr=0, req_len=7, rd_ready toggling 1,0,0,1,... -> exactly 0x01..0x08 in order, no loss or duplication; FIFO never exceeds 4 entries.
- Enable stall: drop en for 5 cycles mid-burst (req_addr=10, req_len=5) -> output gap; sequence still 0x0B..0x10 contiguous; rd_last on 0x10.
- Reset mid-burst: assert rst_n=0 during beat 2 of a 16-beat burst -> all outputs 0 immediately; after release req_ready=1 and no residual beats; a new burst at addr 5 returns 0x06 first.
- With ROM_PARITY_EN: full-table burst (req_len=31) -> rd_parity equals XOR of rd_data for every beat, e.g. 0x03 -> 0, 0x07 -> 1.
